// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg: shared state type and counter width helper for the button event decoder
package btn_evt_pkg;
  typedef enum logic [1:0] {IDLE, PRESS1, GAP, WAIT_REL} btn_evt_state_t;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/button_edge_detect.sv
// button_edge_detect: registers a synchronous level and flags its rising and falling edges
module button_edge_detect #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);
  logic level_q;
  always_ff @(posedge clk)
    level_q <= rst ? INIT : level;
  assign rise = level & ~level_q;
  assign fall = ~level & level_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced button gestures into short, long and double-click pulses
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int N_LONG = 50_000_000,
  parameter int N_DBL  = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_deb,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);
  localparam int CW = cnt_width(N_LONG, N_DBL);
  localparam logic [CW-1:0] LONG_LAST = CW'(N_LONG - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(N_DBL - 1);
  btn_evt_state_t state;
  logic [CW-1:0] cnt;
  logic rise, fall;
  logic [CW-1:0] cnt_inc;
  button_edge_detect #(.INIT(1'b1)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .level(btn_deb),
    .rise (rise),
    .fall (fall)
  );
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    short_press  <= 1'b0;
    long_press   <= 1'b0;
    double_click <= 1'b0;
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:
          if (rise) begin
            state <= PRESS1;
            cnt   <= CW'(1);
          end
        PRESS1:
          if (fall) begin
            state <= GAP;
            cnt   <= CW'(1);
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= WAIT_REL;
          end else
            cnt <= cnt_inc;
        GAP:
          if (rise) begin
            double_click <= 1'b1;
            state        <= WAIT_REL;
          end else if (cnt == DBL_LAST) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end else
            cnt <= cnt_inc;
        WAIT_REL:
          if (!btn_deb)
            state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed checks of gesture classification with N_LONG=8, N_DBL=6
module tb_button_event_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_deb = 1'b1;
  logic short_press, long_press, double_click, busy;
  int checks = 0;
  int errors = 0;
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] BUSY = 4'b0001;
  localparam logic [3:0] SHRT = 4'b1000;
  localparam logic [3:0] LONG = 4'b0101;
  localparam logic [3:0] DBLC = 4'b0011;
  button_event_decoder #(.N_LONG(8), .N_DBL(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_deb     (btn_deb),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .busy        (busy)
  );
  always #5 clk = ~clk;
  task automatic run(input logic b, input int n, input logic [3:0] e, input string tag);
    logic [3:0] obs;
    for (int i = 0; i < n; i++) begin
      btn_deb = b;
      @(posedge clk);
      #1;
      obs = {short_press, long_press, double_click, busy};
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s step %0d obs(s,l,d,busy)=%b exp=%b", tag, i, obs, e);
      end
    end
  endtask
  initial begin
    run(1'b1, 3, NONE, "reset_state");
    rst = 1'b0;
    run(1'b1, 20, NONE, "held_at_reset");
    run(1'b0, 1, NONE, "held_release");
    run(1'b1, 2, BUSY, "post_reset_press");
    run(1'b0, 5, BUSY, "post_reset_gap");
    run(1'b0, 1, SHRT, "post_reset_short");
    run(1'b0, 1, NONE, "post_reset_idle");
    run(1'b1, 3, BUSY, "t1_press");
    run(1'b0, 5, BUSY, "t1_gap");
    run(1'b0, 1, SHRT, "t1_short");
    run(1'b0, 4, NONE, "t1_idle");
    run(1'b1, 7, BUSY, "t2_press");
    run(1'b1, 1, LONG, "t2_long");
    run(1'b1, 12, BUSY, "t2_hold");
    run(1'b0, 4, NONE, "t2_release");
    run(1'b1, 2, BUSY, "t3_press1");
    run(1'b0, 3, BUSY, "t3_gap");
    run(1'b1, 1, DBLC, "t3_double");
    run(1'b1, 1, BUSY, "t3_press2");
    run(1'b0, 8, NONE, "t3_release");
    run(1'b1, 2, BUSY, "t4_press1");
    run(1'b0, 5, BUSY, "t4_gap1");
    run(1'b0, 1, SHRT, "t4_short1");
    run(1'b1, 2, BUSY, "t4_press2");
    run(1'b0, 5, BUSY, "t4_gap2");
    run(1'b0, 1, SHRT, "t4_short2");
    run(1'b0, 2, NONE, "t4_idle");
    run(1'b1, 7, BUSY, "t5_press7");
    run(1'b0, 5, BUSY, "t5_gap");
    run(1'b0, 1, SHRT, "t5_short");
    run(1'b1, 7, BUSY, "t5_press8");
    run(1'b1, 1, LONG, "t5_long");
    run(1'b0, 3, NONE, "t5_release");
    run(1'b1, 2, BUSY, "t6_press");
    run(1'b0, 3, BUSY, "t6_gap");
    rst = 1'b1;
    run(1'b0, 1, NONE, "t6_reset");
    rst = 1'b0;
    run(1'b0, 8, NONE, "t6_after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
